// File: rtl/temporizador_multicanal.sv
// Multi-channel countdown timer with a shared tick prescaler; each channel runs one-shot or periodic.
// Optional sticky interrupt block enabled by defining TEMPORIZADOR_IRQ_EN.
module temporizador_multicanal #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned CNT_W    = 27,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CH-1:0]       enable,
   input  logic [NUM_CH-1:0]       pause,
   input  logic [NUM_CH-1:0]       periodic,
   input  logic [NUM_CH*CNT_W-1:0] period,
`ifdef TEMPORIZADOR_IRQ_EN
   input  logic [NUM_CH-1:0]       irq_clear,
   output logic [NUM_CH-1:0]       irq_status,
   output logic                    irq,
`endif
   output logic [NUM_CH-1:0]       done,
   output logic [NUM_CH-1:0]       expire,
   output logic [NUM_CH*CNT_W-1:0] count
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_e;

   logic [PS_W-1:0]  presc_q, presc_d;
   logic             tick;

   state_e           state_q [NUM_CH];
   state_e           state_d [NUM_CH];
   logic [CNT_W-1:0] cnt_q   [NUM_CH];
   logic [CNT_W-1:0] cnt_d   [NUM_CH];
   logic [CNT_W-1:0] per_q   [NUM_CH];
   logic [CNT_W-1:0] per_d   [NUM_CH];
   logic [NUM_CH-1:0] mode_q, mode_d;
   logic [NUM_CH-1:0] done_q, done_d;
   logic [NUM_CH-1:0] exp_q, exp_d;
   logic [NUM_CH-1:0] last;

   // Shared free-running prescaler
   always_comb begin
      tick    = (presc_q == PS_LAST);
      presc_d = tick ? '0 : presc_q + PS_W'(1);
   end

   // Per-channel next state; a released pause counts in the same cycle so a pause of N clocks delays by N
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         per_d[i]   = per_q[i];
         mode_d[i]  = mode_q[i];
         exp_d[i]   = 1'b0;
         last[i]    = (per_q[i] == '0) || (cnt_q[i] == per_q[i] - CNT_W'(1));
         case (state_q[i])
            IDLE: begin
               cnt_d[i] = '0;
               if (enable[i]) begin
                  per_d[i]   = period[i*CNT_W +: CNT_W];
                  mode_d[i]  = periodic[i];
                  state_d[i] = RUN;
               end
            end
            RUN, PAUSED: begin
               if (!enable[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end else if (pause[i]) begin
                  state_d[i] = PAUSED;
               end else begin
                  state_d[i] = RUN;
                  if (tick) begin
                     if (last[i]) begin
                        exp_d[i] = 1'b1;
                        if (mode_q[i]) cnt_d[i] = '0;
                        else           state_d[i] = DONE;
                     end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                     end
                  end
               end
            end
            DONE: begin
               if (!enable[i]) begin
                  state_d[i] = IDLE;
                  cnt_d[i]   = '0;
               end
            end
            default: begin
               state_d[i] = IDLE;
               cnt_d[i]   = '0;
            end
         endcase
         done_d[i] = (state_d[i] == DONE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         mode_q  <= '0;
         done_q  <= '0;
         exp_q   <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
            per_q[i]   <= '0;
         end
      end else begin
         presc_q <= presc_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         exp_q   <= exp_d;
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            per_q[i]   <= per_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) count[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assign done   = done_q;
   assign expire = exp_q;

`ifdef TEMPORIZADOR_IRQ_EN
   logic [NUM_CH-1:0] irq_st_q, irq_st_d;
   logic              irq_q;

   // Sticky status; a new expiry wins over a simultaneous clear
   assign irq_st_d = (irq_st_q & ~irq_clear) | exp_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_st_q <= '0;
         irq_q    <= 1'b0;
      end else begin
         irq_st_q <= irq_st_d;
         irq_q    <= |irq_st_q;
      end
   end

   assign irq_status = irq_st_q;
   assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_temporizador_multicanal.sv
// Bench for temporizador_multicanal: directed literal checks plus randomized run against a behavioural model.
module tb_temporizador_multicanal;

   localparam int NA = 4, WA = 4, PA = 1;
   localparam int NB = 2, WB = 6, PB = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic [NA-1:0]    en_a = '0, pa_a = '0, mo_a = '0;
   logic [NA*WA-1:0] per_a = '0;
   logic [NA-1:0]    done_a, expire_a;
   logic [NA*WA-1:0] count_a;
   logic [NB-1:0]    en_b = '0, pa_b = '0, mo_b = '0;
   logic [NB*WB-1:0] per_b = '0;
   logic [NB-1:0]    done_b, expire_b;
   logic [NB*WB-1:0] count_b;
`ifdef TEMPORIZADOR_IRQ_EN
   logic [NA-1:0] clr_a = '0, irqs_a;
   logic [NB-1:0] clr_b = '0, irqs_b;
   logic          irq_a, irq_b;
   logic [NA-1:0] m_st_a = '0;
   logic [NB-1:0] m_st_b = '0;
   logic          m_irq_a = 1'b0, m_irq_b = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   temporizador_multicanal #(.NUM_CH(NA), .CNT_W(WA), .PRESCALE(PA)) u_a (
      .clk(clk), .reset_n(reset_n), .enable(en_a), .pause(pa_a), .periodic(mo_a), .period(per_a),
`ifdef TEMPORIZADOR_IRQ_EN
      .irq_clear(clr_a), .irq_status(irqs_a), .irq(irq_a),
`endif
      .done(done_a), .expire(expire_a), .count(count_a));

   temporizador_multicanal #(.NUM_CH(NB), .CNT_W(WB), .PRESCALE(PB)) u_b (
      .clk(clk), .reset_n(reset_n), .enable(en_b), .pause(pa_b), .periodic(mo_b), .period(per_b),
`ifdef TEMPORIZADOR_IRQ_EN
      .irq_clear(clr_b), .irq_status(irqs_b), .irq(irq_b),
`endif
      .done(done_b), .expire(expire_b), .count(count_b));

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit          act;
      bit          fin;
      int unsigned cnt;
      int unsigned per;
      bit          mode;
   } ch_t;

   ch_t ma [NA];
   ch_t mb [NB];
   int  pc_a = 0, pc_b = 0;
   logic [NA-1:0]    m_done_a = '0, m_exp_a = '0;
   logic [NA*WA-1:0] m_cnt_a = '0;
   logic [NB-1:0]    m_done_b = '0, m_exp_b = '0;
   logic [NB*WB-1:0] m_cnt_b = '0;

   // One clock of one channel: the expiry happens on the tick that would make elapsed reach the period
   task automatic step_ch(inout ch_t c, input bit en, input bit ps, input bit mo,
                          input int unsigned pr, input bit tk, output bit ex);
      int unsigned lim;
      ex = 1'b0;
      if (!en) begin
         c.act = 0; c.fin = 0; c.cnt = 0;
      end else if (!c.act && !c.fin) begin
         c.act = 1; c.cnt = 0; c.per = pr; c.mode = mo;
      end else if (c.act && !ps && tk) begin
         lim = (c.per == 0) ? 1 : c.per;
         if (c.cnt + 1 >= lim) begin
            ex = 1'b1;
            if (c.mode) c.cnt = 0;
            else begin c.act = 0; c.fin = 1; end
         end else begin
            c.cnt = c.cnt + 1;
         end
      end
   endtask

   initial begin
      bit tk, ex;
      for (int i = 0; i < NA; i++) ma[i] = '{0, 0, 0, 0, 0};
      for (int i = 0; i < NB; i++) mb[i] = '{0, 0, 0, 0, 0};
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            for (int i = 0; i < NA; i++) ma[i] = '{0, 0, 0, 0, 0};
            for (int i = 0; i < NB; i++) mb[i] = '{0, 0, 0, 0, 0};
            pc_a = 0; pc_b = 0;
            m_done_a = '0; m_exp_a = '0; m_cnt_a = '0;
            m_done_b = '0; m_exp_b = '0; m_cnt_b = '0;
`ifdef TEMPORIZADOR_IRQ_EN
            m_st_a = '0; m_st_b = '0; m_irq_a = 1'b0; m_irq_b = 1'b0;
`endif
         end else begin
            tk = (pc_a == PA - 1);
            pc_a = tk ? 0 : pc_a + 1;
            for (int i = 0; i < NA; i++) begin
               step_ch(ma[i], en_a[i], pa_a[i], mo_a[i], int'(per_a[i*WA +: WA]), tk, ex);
               m_exp_a[i] = ex;
               m_done_a[i] = ma[i].fin;
               m_cnt_a[i*WA +: WA] = WA'(ma[i].cnt);
            end
            tk = (pc_b == PB - 1);
            pc_b = tk ? 0 : pc_b + 1;
            for (int i = 0; i < NB; i++) begin
               step_ch(mb[i], en_b[i], pa_b[i], mo_b[i], int'(per_b[i*WB +: WB]), tk, ex);
               m_exp_b[i] = ex;
               m_done_b[i] = mb[i].fin;
               m_cnt_b[i*WB +: WB] = WB'(mb[i].cnt);
            end
`ifdef TEMPORIZADOR_IRQ_EN
            m_irq_a = |m_st_a;
            m_st_a  = (m_st_a & ~clr_a) | m_exp_a;
            m_irq_b = |m_st_b;
            m_st_b  = (m_st_b & ~clr_b) | m_exp_b;
`endif
         end
      end
   end

   // Every-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (reset_n) begin
            chk("model_count_a", 64'(count_a), 64'(m_cnt_a));
            chk("model_done_a", 64'(done_a), 64'(m_done_a));
            chk("model_expire_a", 64'(expire_a), 64'(m_exp_a));
            chk("model_count_b", 64'(count_b), 64'(m_cnt_b));
            chk("model_done_b", 64'(done_b), 64'(m_done_b));
            chk("model_expire_b", 64'(expire_b), 64'(m_exp_b));
`ifdef TEMPORIZADOR_IRQ_EN
            chk("model_irqs_a", 64'(irqs_a), 64'(m_st_a));
            chk("model_irq_a", 64'(irq_a), 64'(m_irq_a));
            chk("model_irqs_b", 64'(irqs_b), 64'(m_st_b));
            chk("model_irq_b", 64'(irq_b), 64'(m_irq_b));
`endif
         end
      end
   end

   // Negedges until expire on a channel, bounded
   task automatic wait_exp_a(input int ch, input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!expire_a[ch] && n < bound);
   endtask

   task automatic wait_exp_b(input int ch, input int bound, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!expire_b[ch] && n < bound);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_count_a", 64'(count_a), 64'd0);
      chk("rst_done_a", 64'(done_a), 64'd0);
      chk("rst_expire_b", 64'(expire_b), 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // One-shot, period 3 on A ch0
      en_a[0] = 1'b1; per_a[3:0] = 4'd3; mo_a[0] = 1'b0;
      @(negedge clk); chk("os_cnt_e0", 64'(count_a[3:0]), 64'd0);
      @(negedge clk); chk("os_cnt_e1", 64'(count_a[3:0]), 64'd1);
      @(negedge clk); chk("os_cnt_e2", 64'(count_a[3:0]), 64'd2);
      chk("os_noexp_e2", 64'(expire_a[0]), 64'd0);
      @(negedge clk); chk("os_exp_e3", 64'(expire_a[0]), 64'd1);
      chk("os_done_e3", 64'(done_a[0]), 64'd1);
      chk("os_cnt_e3", 64'(count_a[3:0]), 64'd2);
      chk("os_ch1_idle", 64'(count_a[7:4]), 64'd0);
      @(negedge clk); chk("os_exp_drop", 64'(expire_a[0]), 64'd0);
      chk("os_done_hold", 64'(done_a[0]), 64'd1);
      chk("os_cnt_hold", 64'(count_a[3:0]), 64'd2);
      en_a[0] = 1'b0;
      @(negedge clk); chk("os_done_clr", 64'(done_a[0]), 64'd0);
      chk("os_cnt_clr", 64'(count_a[3:0]), 64'd0);

      // Pause for 5 clocks at count 4, period 10, on A ch1
      en_a[1] = 1'b1; per_a[7:4] = 4'd10;
      repeat (5) @(negedge clk);
      chk("pz_cnt4", 64'(count_a[7:4]), 64'd4);
      pa_a[1] = 1'b1;
      repeat (5) @(negedge clk);
      chk("pz_hold4", 64'(count_a[7:4]), 64'd4);
      pa_a[1] = 1'b0;
      wait_exp_a(1, 40, n);
      chk("pz_delay", 64'(n), 64'd6);
      en_a[1] = 1'b0;

      // Abort at count 6 on A ch2
      en_a[2] = 1'b1; per_a[11:8] = 4'd12;
      repeat (7) @(negedge clk);
      chk("ab_cnt6", 64'(count_a[11:8]), 64'd6);
      en_a[2] = 1'b0;
      @(negedge clk); chk("ab_cnt0", 64'(count_a[11:8]), 64'd0);
      chk("ab_noexp", 64'(expire_a[2]), 64'd0);

      // Period changed while running is ignored
      en_a[3] = 1'b1; per_a[15:12] = 4'd5;
      @(negedge clk); per_a[15:12] = 4'd9;
      wait_exp_a(3, 40, n);
      chk("latch_old_period", 64'(n), 64'd5);
      en_a[3] = 1'b0;

      // Period 0 expires on the first tick
      en_a[0] = 1'b1; per_a[3:0] = 4'd0;
      wait_exp_a(0, 40, n);
      chk("p0_first_tick", 64'(n), 64'd2);
      chk("p0_done", 64'(done_a[0]), 64'd1);
      en_a[0] = 1'b0;

      // Maximum period 15 with CNT_W=4: expires at count 14
      en_a[2] = 1'b1; per_a[11:8] = 4'd15;
      wait_exp_a(2, 60, n);
      chk("pmax_latency", 64'(n), 64'd16);
      chk("pmax_cnt14", 64'(count_a[11:8]), 64'd14);
      en_a[2] = 1'b0;

      // Periodic period 4 with PRESCALE 2 on B ch0: expiry every 8 clocks
      en_b[0] = 1'b1; per_b[5:0] = 6'd4; mo_b[0] = 1'b1;
      wait_exp_b(0, 40, n);
      for (int k = 0; k < 5; k++) begin
         wait_exp_b(0, 40, n);
         chk("per_interval", 64'(n), 64'd8);
         chk("per_done0", 64'(done_b[0]), 64'd0);
      end

      // Asynchronous reset mid-count
      en_a[1] = 1'b1; per_a[7:4] = 4'd12;
      repeat (4) @(negedge clk);
      @(posedge clk); #2 reset_n = 1'b0;
      #1;
      chk("arst_count_a", 64'(count_a), 64'd0);
      chk("arst_count_b", 64'(count_b), 64'd0);
      chk("arst_done_exp", 64'({done_a, expire_a, done_b, expire_b}), 64'd0);
      @(negedge clk); reset_n = 1'b1;
      en_a = '0; en_b = '0; mo_b = '0;

      // Randomized run
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < NA; i++) begin
            if ($urandom_range(0, 15) == 0) en_a[i] = ~en_a[i];
            if ($urandom_range(0, 7) == 0) pa_a[i] = ~pa_a[i];
            mo_a[i] = 1'($urandom_range(0, 1));
            per_a[i*WA +: WA] = WA'($urandom_range(0, 15));
         end
         for (int i = 0; i < NB; i++) begin
            if ($urandom_range(0, 15) == 0) en_b[i] = ~en_b[i];
            if ($urandom_range(0, 7) == 0) pa_b[i] = ~pa_b[i];
            mo_b[i] = 1'($urandom_range(0, 1));
            per_b[i*WB +: WB] = WB'($urandom_range(0, 9));
         end
`ifdef TEMPORIZADOR_IRQ_EN
         clr_a = NA'($urandom_range(0, 15)) & NA'($urandom_range(0, 15));
         clr_b = NB'($urandom_range(0, 3)) & NB'($urandom_range(0, 3));
`endif
      end
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/temporizador_multicanal.md
# temporizador_multicanal

Parametrised multi-channel countdown timer that generalises the single-channel win-display timer. It adds N independent channels, per-channel programmable periods, one-shot or periodic mode, pause/hold and a shared tick prescaler. It sits beside the game FSMs on the 25.175 MHz pixel clock and supplies every timeout the game needs: win-screen hold, turn timer and blink cadence.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1).
- `CNT_W`, 27: counter and period width in bits; 27 bits covers 2 s at 25.175 MHz.
- `PRESCALE`, 1: clocks per tick (≥1); 1 gives one tick every clock.
- `clk`  in  1: system clock (pixel clock).
- `reset_n`  in  1: asynchronous reset, active-low.
- `enable`  in  NUM_CH: per-channel run request; low forces the channel to IDLE.
- `pause`  in  NUM_CH: per-channel hold; the count freezes while high.
- `periodic`  in  NUM_CH: mode, sampled at start; 1 = periodic, 0 = one-shot.
- `period`  in  NUM_CH*CNT_W: packed per-channel period in ticks; channel i uses bits [i*CNT_W +: CNT_W].
- `done`  out  NUM_CH: level output; high in the DONE state (one-shot mode only).
- `expire`  out  NUM_CH: one-clock pulse on each expiry, in both modes.
- `count`  out  NUM_CH*CNT_W: packed elapsed-tick count per channel.

## Operation
- **Prescaler**
  - Shared free-running counter, 0..PRESCALE-1.
  - `tick` strobes when the prescaler equals PRESCALE-1.
  - Runs whenever out of reset, independent of the channels.
- **States per channel:** IDLE, RUN, PAUSED, DONE.
- **IDLE**
  - Count is 0, `done` is 0.
  - If `enable[i]` is high: latch `period[i]` and `periodic[i]` into shadow registers, clear the count, go to RUN.
- **RUN**
  - `enable` low → IDLE.
  - Otherwise, `pause` high → PAUSED; no count this cycle.
  - Otherwise, on `tick`:
    - If count == latched period − 1, or latched period == 0: expiry.
    - Else count increments by 1.
- **Expiry**
  - `expire[i]` pulses for 1 clk.
  - One-shot: go to DONE and hold the count.
  - Periodic: clear the count to 0 and stay in RUN.
- **PAUSED:** count holds; `enable` low → IDLE; `pause` low → RUN.
- **DONE:** `done` = 1, count holds; `enable` low → IDLE.
- **Latched values:** `period` and `periodic` changes while not in IDLE are ignored until the next IDLE→RUN start.
- **Independence:** channels share only the prescaler.

## Timing
- **Reset values:** all outputs 0, all channels IDLE, prescaler 0, shadow registers 0.
- **Outputs:** all registered; no combinational path from any input to any output.
- **Start latency:** `enable` sampled high at edge E0 → RUN after E0. The first counting tick can be at E1.
- **Expiry latency:** with PRESCALE=1 and period=P≥1, `expire` and `done` go high after edge E0+P. The `expire` pulse drops one edge later.
- **Periodic mode:** `expire` pulses every P ticks, i.e. every P·PRESCALE clocks at steady state.
- **Priority:** `enable` low > `pause` > tick/expiry. A pause sampled in the same cycle as the expiring tick suppresses the expiry until resumed.
- **Wrap-around:** count never exceeds period−1; no wrap at 2^CNT_W. Period 0 behaves exactly as period 1.
- **Reset mid-operation:** asynchronous clear to reset values; no pending pulse survives.
- **Restart from DONE:** `enable` must go low for ≥1 clk. Holding `enable` high keeps DONE.

## Configuration
- `TEMPORIZADOR_IRQ_EN` defined adds three things:
  - Input `irq_clear` (NUM_CH bits).
  - Output `irq_status` (NUM_CH bits, sticky; set by `expire[i]`, cleared by `irq_clear[i]`; set wins when both occur in the same cycle).
  - Output `irq` (1 bit, registered OR of `irq_status`).
  - All three reset to 0.
- `TEMPORIZADOR_IRQ_EN` undefined: these ports and registers are absent; all other behaviour is identical.

## Test plan
- **One-shot:** NUM_CH=2, PRESCALE=1, period0=3, enable0 raised → `expire[0]` a single pulse and `done[0]` high exactly 3 edges after the RUN entry; count0 holds 2; channel 1 stays 0.
- **Periodic:** period=4, PRESCALE=2, periodic=1 → `expire` pulses every 8 clocks for ≥5 periods; count cycles 0..3; `done` stays 0.
- **Pause:** period=10, pause high for 5 clk at count 4 → count holds 4 while paused; expiry delayed by exactly 5 clk.
- **Abort and latch:** enable dropped at count 6 → count 0 next cycle, no `expire`. Period changed while in RUN → old period still used until restart.
- **Boundaries:**
  - period=0 expires on the first tick.
  - period=2^CNT_W−1 with small CNT_W=4 → expires at count 14, no wrap.
  - `reset_n` pulsed mid-count → all outputs 0 asynchronously.
- **IRQ (with TEMPORIZADOR_IRQ_EN):** expiry on ch1 → `irq_status`=0b0010 and `irq` high. `irq_clear` coinciding with a new expiry keeps the bit set; `irq_clear` alone clears it.
